// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared constants for the elastic inter-stage pipeline registers
//   NOP_INSTR  : addi x0,x0,0, the value loaded into empty/flushed stages
//   DEF_WIDTH  : default payload width
//   DEF_CNT_W  : default stall counter width
package rv_pipe_pkg;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one {valid, data} pipeline register with load-enable, flush and reset-to-NOP
//   clk, reset       : clock, synchronous active-high reset
//   flush            : squash the entry (valid=0, data=NOP)
//   load             : take in_valid/in_data this cycle, otherwise hold
//   in_valid/in_data : entry offered by the predecessor
//   valid/data       : registered entry
module pipe_stage import rv_pipe_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] NOP = WIDTH'(NOP_INSTR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             load,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);
   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d, data_q;
   // an invalid incoming entry loads NOP so empty stages always read as NOP
   always_comb begin
      valid_d = flush ? 1'b0 : load ? in_valid : valid_q;
      data_d  = flush ? NOP : load ? (in_valid ? in_data : NOP) : data_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= NOP;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end
   assign valid = valid_q;
   assign data  = data_q;
endmodule

// File: rtl/stall_flush_pipe.sv
// stall_flush_pipe: elastic DEPTH-stage pipeline register chain with bubble collapsing and flush
//   clk, reset           : clock, synchronous active-high reset
//   flush                : squash every in-flight entry next cycle
//   in_valid/in_data     : upstream entry, in_ready = chain accepts it this cycle
//   out_valid/out_data   : last stage entry, consumed when out_ready
//   occupancy            : number of valid stages
//   stall_cnt            : saturating count of cycles with out_valid && !out_ready
module stall_flush_pipe import rv_pipe_pkg::*; #(
   parameter int          WIDTH   = DEF_WIDTH,
   parameter int          DEPTH   = 2,
   parameter logic [31:0] NOP_VAL = NOP_INSTR,
   parameter int          CNT_W   = DEF_CNT_W,
   localparam int         OCC_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [OCC_W-1:0] occupancy,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_VAL);
   logic [DEPTH-1:0] v, rdy, src_v;
   logic [WIDTH-1:0] d     [DEPTH];
   logic [WIDTH-1:0] src_d [DEPTH];
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   // ready ripples back from the output: a stage may load if it is empty or its successor moves
   always_comb begin
      rdy = '0;
      rdy[DEPTH-1] = !v[DEPTH-1] || out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) rdy[i] = !v[i] || rdy[i+1];
   end
   always_comb begin
      src_v = '0;
      src_v[0] = in_valid;
      src_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         src_v[i] = v[i-1];
         src_d[i] = d[i-1];
      end
   end
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      pipe_stage #(.WIDTH(WIDTH), .NOP(NOP_W)) u_stage (
         .clk      (clk),
         .reset    (reset),
         .flush    (flush),
         .load     (rdy[i]),
         .in_valid (src_v[i]),
         .in_data  (src_d[i]),
         .valid    (v[i]),
         .data     (d[i])
      );
   end
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(v[i]);
   end
   // stall counter ignores flush and saturates instead of wrapping
   always_comb begin
      stall_cnt_d = (out_valid && !out_ready && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
   end
   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= '0;
      else stall_cnt_q <= stall_cnt_d;
   end
   assign in_ready  = rdy[0];
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];
   assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_stall_flush_pipe.sv
// tb_stall_flush_pipe: random and directed stimulus on three chain configurations vs a queue model
module tb_stall_flush_pipe;
   localparam int NI = 3;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic clk, reset, flush, in_valid, out_ready;
   logic [31:0] in_data;
   logic ir [NI];
   logic ov [NI];
   logic [31:0] od [NI];
   logic [31:0] oc [NI];
   logic [31:0] sc [NI];
   logic [1:0] oc0, oc1;
   logic [0:0] oc2;
   logic [15:0] sc0, sc1;
   logic [3:0] sc2;
   int n_checks = 0, n_errors = 0;
   bit armed = 0;
   int mpos [NI][4];
   logic [31:0] mdat [NI][4];
   int mcnt [NI];
   int msc [NI];

   stall_flush_pipe #(.DEPTH(2)) u0 (.clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
      .in_data(in_data), .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
      .occupancy(oc0), .stall_cnt(sc0));
   stall_flush_pipe #(.DEPTH(3)) u1 (.clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
      .in_data(in_data), .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
      .occupancy(oc1), .stall_cnt(sc1));
   stall_flush_pipe #(.DEPTH(1), .CNT_W(4)) u2 (.clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
      .in_data(in_data), .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready),
      .occupancy(oc2), .stall_cnt(sc2));

   assign oc[0] = 32'(oc0);
   assign oc[1] = 32'(oc1);
   assign oc[2] = 32'(oc2);
   assign sc[0] = 32'(sc0);
   assign sc[1] = 32'(sc1);
   assign sc[2] = 32'(sc2);

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic int dep_of(input int k);
      return k == 0 ? 2 : k == 1 ? 3 : 1;
   endfunction

   function automatic int smax_of(input int k);
      return k == 2 ? 15 : 65535;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, compare outputs with the model, then advance the model.
   // The model keeps each chain as an ordered list of entries (oldest first) with a position;
   // an entry advances when the slot ahead is free after the older entry's own move.
   task automatic step(input logic iv, input logic [31:0] id, input logic ordy, input logic fl, input logic rs);
      int dd, n, lim, j;
      int np [4];
      bit exp_ov, exp_ir, leave;
      @(negedge clk);
      in_valid = iv;
      in_data = id;
      out_ready = ordy;
      flush = fl;
      reset = rs;
      #1;
      for (int k = 0; k < NI; k++) begin
         dd = dep_of(k);
         n = mcnt[k];
         exp_ov = n > 0 && mpos[k][0] == dd - 1;
         leave = exp_ov && ordy;
         lim = dd;
         for (int i = 0; i < n; i++) begin
            if (i == 0 && leave) np[i] = dd;
            else np[i] = (mpos[k][i] + 1 < lim) ? mpos[k][i] + 1 : mpos[k][i];
            lim = np[i];
         end
         exp_ir = n == 0 || np[n-1] > 0;
         if (armed) begin
            chk($sformatf("u%0d out_valid", k), 32'(ov[k]), 32'(exp_ov));
            chk($sformatf("u%0d out_data", k), od[k], exp_ov ? mdat[k][0] : NOP);
            chk($sformatf("u%0d occupancy", k), oc[k], 32'(n));
            chk($sformatf("u%0d in_ready", k), 32'(ir[k]), 32'(exp_ir));
            chk($sformatf("u%0d stall_cnt", k), sc[k], 32'(msc[k]));
         end
         if (rs) begin
            mcnt[k] = 0;
            msc[k] = 0;
         end else begin
            if (exp_ov && !ordy && msc[k] < smax_of(k)) msc[k]++;
            if (fl) mcnt[k] = 0;
            else begin
               j = 0;
               for (int i = 0; i < n; i++) begin
                  if (np[i] < dd) begin
                     mpos[k][j] = np[i];
                     mdat[k][j] = mdat[k][i];
                     j++;
                  end
               end
               if (iv && exp_ir) begin
                  mpos[k][j] = 0;
                  mdat[k][j] = id;
                  j++;
               end
               mcnt[k] = j;
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         mcnt[k] = 0;
         msc[k] = 0;
      end
      reset = 1;
      flush = 0;
      in_valid = 0;
      in_data = 0;
      out_ready = 0;
      step(0, 0, 0, 0, 1);
      armed = 1;
      step(0, 0, 0, 0, 1);
      // streaming
      step(1, 32'h100, 1, 0, 0);
      step(1, 32'h104, 1, 0, 0);
      step(1, 32'h108, 1, 0, 0);
      repeat (4) step(0, 0, 1, 0, 0);
      // backpressure with a bubble, then release
      step(1, 32'hA, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 32'hB, 0, 0, 0);
      step(1, 32'hC, 0, 0, 0);
      step(1, 32'hD, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      repeat (6) step(0, 0, 1, 0, 0);
      // flush a full chain with an input offered
      repeat (4) step(1, $urandom, 0, 0, 0);
      step(1, 32'hDEAD, 0, 1, 0);
      repeat (4) step(0, 0, 1, 0, 0);
      // full chain, accept and consume every cycle
      repeat (3) step(1, $urandom, 0, 0, 0);
      repeat (10) step(1, $urandom, 1, 0, 0);
      // long stall to saturate the narrow counter
      repeat (20) step(1, $urandom, 0, 0, 0);
      // reset while full
      repeat (2) step(1, $urandom, 0, 0, 1);
      step(0, 0, 1, 0, 0);
      // random traffic
      repeat (3000)
         step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
              $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/stall_flush_pipe.md
# stall_flush_pipe

Parametrised, elastic pipeline-register chain for the pipelined RISC-V core. It generalises the stage register between pipeline stages: configurable payload width and stage count, a per-stage valid bit, backpressure through a ready/valid handshake with bubble collapsing, and a synchronous flush that squashes all in-flight entries to a NOP. It sits between fetch and decode (instruction/PC bundle) and is reused for other inter-stage bundles.

## Interface
- WIDTH, 32: payload bits per entry.
- DEPTH, 2: number of register stages, ≥1.
- NOP_VAL, 32'h0000_0013: data value loaded on reset/flush (addi x0,x0,0), truncated/zero-extended to WIDTH.
- CNT_W, 16: width of stall counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash all entries this cycle (branch/jump redirect).
- in_valid  in  1  upstream offers an entry.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  chain accepts the entry this cycle (stall to upstream = !in_ready).
- out_valid  out  1  stage DEPTH-1 holds a valid entry.
- out_data  out  WIDTH  stage DEPTH-1 payload.
- out_ready  in  1  downstream consumes this cycle.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready.

## Operation
- Each stage i holds {v[i], d[i]}. Stage 0 is fed by the input; stage DEPTH-1 drives the outputs.
- Stage ready: rdy[DEPTH-1] = !v[DEPTH-1] || out_ready; rdy[i] = !v[i] || rdy[i+1]. in_ready = rdy[0] (combinational, no flush term).
- When rdy[i], stage i loads from its predecessor (valid and data); when !rdy[i], it holds. An invalid stage always loads, so bubbles collapse and a stalled output does not block filling of empty upstream stages.
- Data of a stage loading an invalid entry is don't-care; the implementation loads NOP_VAL.
- Transfers: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready. Entries leave in arrival order; none dropped or duplicated, except on flush.
- flush (priority over everything except reset): next cycle all v = 0, all d = NOP_VAL. Any entry handed over on the flush cycle (including an in_valid && in_ready input) is discarded; an out_valid && out_ready transfer on the flush cycle counts as consumed.
- occupancy = popcount(v), registered-state derived (combinational from v).
- stall_cnt: +1 each cycle out_valid && !out_ready, saturates at all-ones, unaffected by flush, cleared only by reset.
- Arithmetic: occupancy never exceeds DEPTH; stall_cnt never wraps.

## Timing
- Reset: v = 0, d = NOP_VAL, so out_valid = 0, out_data = NOP_VAL, occupancy = 0, stall_cnt = 0, in_ready = 1 from the first cycle after reset. reset mid-operation discards all entries.
- Latency: empty chain, out_ready high: input accepted at edge t is out_valid after edge t+DEPTH-1 (i.e. DEPTH cycles visible latency counting the accept cycle as 1). Throughput one entry/cycle.
- Full chain (occupancy = DEPTH) with out_ready = 0: in_ready = 0. With out_ready = 1 on a full chain: in_ready = 1, simultaneous accept and consume, occupancy unchanged.
- in_ready depends combinationally on out_ready through DEPTH levels; out_valid/out_data are pure register outputs.
- DEPTH = 1 reduces to a single stall-able register with valid and flush.

## Structure
- Shared package rv_pipe_pkg: NOP_INSTR constant (32'h0000_0013), default WIDTH/CNT_W constants.
- One sub-module pipe_stage: a single {valid, data} register with load-enable, flush and reset-to-NOP, instantiated DEPTH times in a generate loop; top level holds the ready chain, occupancy popcount and stall counter.

## Test plan
- Reset: assert reset 2 cycles mid-stream with DEPTH=2 full -> next cycle out_valid=0, out_data=32'h13, occupancy=0, stall_cnt=0, in_ready=1.
- Streaming: out_ready=1, push 0x100,0x104,0x108 back-to-back -> out_valid rises 2 cycles after first accept, outputs 0x100,0x104,0x108 on consecutive cycles.
- Backpressure/bubble collapse: DEPTH=3, push A, gap, B with out_ready=0 -> occupancy reaches 2 then 3 after C, in_ready=0 when full; release out_ready -> A,B,C in order, stall_cnt equals cycles held.
- Flush: full chain, flush=1 with in_valid=1 -> next cycle occupancy=0, out_data=32'h13, flushed input never appears; stall_cnt unchanged.
- Simultaneous: full DEPTH=2, out_ready=1 and in_valid=1 every cycle for 10 cycles -> occupancy stays 2, no loss.
- Saturation: CNT_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_cnt stops at 4'hF.
